// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: frame FSM encoding, prefix bytes,
// event layout {EXT, BREAK, CODE[7:0]} and parity/error-code helpers.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;
    localparam int         EVT_W      = 10;

    // PS/2 uses odd parity across the eight data bits plus the parity bit
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // 00 and FF are keyboard overrun/error reports, never real scancodes
    function automatic logic is_err_code(input logic [7:0] code);
        return (code == 8'h00) || (code == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event FIFO with a registered head word. A push while full
// is dropped (ovf_set) unless a pop happens in the same cycle.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = EVT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       rd_valid,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ovf_set
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] head_r;
    logic             valid_r;

    logic             pop_s;
    logic             full_s;
    logic             wr_en_s;
    logic [AW-1:0]    rd_ptr_next_s;
    logic [CW-1:0]    count_next_s;
    logic [CW-1:0]    remain_s;
    logic [WIDTH-1:0] head_next_s;

    assign pop_s   = pop && valid_r;
    assign full_s  = (count_r == CW'(DEPTH));
    assign wr_en_s = push && (!full_s || pop_s);
    assign ovf_set = push && full_s && !pop_s;

    // Next occupancy, read pointer and head word
    always_comb begin
        count_next_s  = count_r;
        rd_ptr_next_s = rd_ptr_r;
        remain_s      = count_r;
        head_next_s   = head_r;
        case ({wr_en_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + AW'(1);
            remain_s      = count_r - CW'(1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
            remain_s      = count_r;
        end
        // An empty queue after the pop means the incoming word becomes the head directly
        if (remain_s != CW'(0)) begin
            head_next_s = mem_r[rd_ptr_next_s];
        end else if (wr_en_s) begin
            head_next_s = push_data;
        end else begin
            head_next_s = head_r;
        end
    end

    // Pointer, count and head registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            head_r   <= '0;
            valid_r  <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_next_s;
            head_r   <= head_next_s;
            valid_r  <= (count_next_s != CW'(0));
        end
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign rd_valid = valid_r;
    assign rd_data  = head_r;
    assign count    = count_r;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronise + glitch-filter the lines, decode 11-bit frames,
// fold E0/F0 prefixes into flags and queue events. Define PS2_RX_PARITY_CHECK_EN to reject bad parity.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic                            PS2_CLK,
    input  logic                            PS2_DAT,
    output logic                            EVT_VALID,
    input  logic                            EVT_READY,
    output logic [7:0]                      EVT_CODE,
    output logic                            EVT_EXT,
    output logic                            EVT_BREAK,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] FIFO_COUNT,
    output logic                            OVERFLOW,
    output logic                            FRAME_ERR,
    input  logic                            CLR_ERR
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    // Lane 0 is PS2_CLK, lane 1 is PS2_DAT
    logic [1:0]          meta_r;
    logic [1:0]          sync_r;
    logic [1:0]          filt_r;
    logic [1:0]          filt_d_r;
    logic [1:0][FCW-1:0] flt_cnt_r;
    logic                fall_s;
    logic                dat_s;

    ps2_state_e          state_r, state_s;
    logic [7:0]          shift_r, shift_s;
    logic [2:0]          bit_cnt_r, bit_cnt_s;
    logic                par_r, par_s;
    logic [TCW-1:0]      tmo_r, tmo_s;
    logic                ext_r, ext_s;
    logic                brk_r, brk_s;
    logic                push_s, err_s, par_ok_s;
    logic                push_r;
    logic [EVT_W-1:0]    push_data_r, push_data_s;
    logic                frame_err_r;
    logic                overflow_r;
    logic                ovf_set_s;
    logic [EVT_W-1:0]    head_s;

    // Two-flop synchroniser, idles high like the bus
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta_r <= 2'b11;
            sync_r <= 2'b11;
        end else begin
            meta_r <= {PS2_DAT, PS2_CLK};
            sync_r <= meta_r;
        end
    end

    // Glitch filter: a level change is accepted after FILTER_LEN consecutive differing samples
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            filt_r    <= 2'b11;
            filt_d_r  <= 2'b11;
            flt_cnt_r <= '0;
        end else begin
            filt_d_r <= filt_r;
            for (int i = 0; i < 2; i++) begin
                if (sync_r[i] == filt_r[i]) begin
                    flt_cnt_r[i] <= '0;
                end else if (flt_cnt_r[i] == FCW'(FILTER_LEN - 1)) begin
                    filt_r[i]    <= sync_r[i];
                    flt_cnt_r[i] <= '0;
                end else begin
                    flt_cnt_r[i] <= flt_cnt_r[i] + FCW'(1);
                end
            end
        end
    end

    assign fall_s = filt_d_r[0] & ~filt_r[0];
    assign dat_s  = filt_r[1];

`ifdef PS2_RX_PARITY_CHECK_EN
    assign par_ok_s = odd_parity_ok(shift_r, par_r);
`else
    assign par_ok_s = 1'b1;
`endif

    // Frame FSM next-state, timeout and prefix tracking
    always_comb begin
        state_s     = state_r;
        shift_s     = shift_r;
        bit_cnt_s   = bit_cnt_r;
        par_s       = par_r;
        tmo_s       = tmo_r;
        ext_s       = ext_r;
        brk_s       = brk_r;
        push_s      = 1'b0;
        err_s       = 1'b0;
        push_data_s = {ext_r, brk_r, shift_r};

        if (state_r == ST_IDLE) begin
            tmo_s = '0;
        end else if (fall_s) begin
            tmo_s = '0;
        end else begin
            tmo_s = tmo_r + TCW'(1);
        end

        case (state_r)
            ST_IDLE: begin
                if (fall_s && !dat_s) begin
                    state_s   = ST_DATA;
                    bit_cnt_s = 3'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (fall_s) begin
                    shift_s   = {dat_s, shift_r[7:1]};
                    bit_cnt_s = bit_cnt_r + 3'd1;
                    state_s   = (bit_cnt_r == 3'd7) ? ST_PARITY : ST_DATA;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (fall_s) begin
                    par_s   = dat_s;
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (fall_s) begin
                    state_s = ST_IDLE;
                    if (!dat_s || !par_ok_s) begin
                        err_s = 1'b1;
                    end else if (shift_r == PREFIX_EXT) begin
                        ext_s = 1'b1;
                    end else if (shift_r == PREFIX_BRK) begin
                        brk_s = 1'b1;
                    end else if (is_err_code(shift_r)) begin
                        err_s = 1'b1;
                        ext_s = 1'b0;
                        brk_s = 1'b0;
                    end else begin
                        push_s = 1'b1;
                        ext_s  = 1'b0;
                        brk_s  = 1'b0;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // A stalled keyboard clock abandons the partial frame
        if ((state_r != ST_IDLE) && !fall_s && (tmo_r == TCW'(TIMEOUT_CYCLES - 1))) begin
            state_s = ST_IDLE;
            tmo_s   = '0;
            err_s   = 1'b1;
        end else begin
            err_s = err_s;
        end
    end

    // Frame FSM and pipeline registers; push lands one cycle after the stop edge
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            shift_r     <= 8'h00;
            bit_cnt_r   <= 3'd0;
            par_r       <= 1'b0;
            tmo_r       <= '0;
            ext_r       <= 1'b0;
            brk_r       <= 1'b0;
            push_r      <= 1'b0;
            push_data_r <= '0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            shift_r     <= shift_s;
            bit_cnt_r   <= bit_cnt_s;
            par_r       <= par_s;
            tmo_r       <= tmo_s;
            ext_r       <= ext_s;
            brk_r       <= brk_s;
            push_r      <= push_s;
            push_data_r <= push_data_s;
            frame_err_r <= err_s;
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RST_N),
        .push      (push_r),
        .push_data (push_data_r),
        .pop       (EVT_READY),
        .rd_valid  (EVT_VALID),
        .rd_data   (head_s),
        .count     (FIFO_COUNT),
        .ovf_set   (ovf_set_s)
    );

    // Sticky overflow; a same-cycle drop wins over the clear
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            overflow_r <= 1'b0;
        end else if (ovf_set_s) begin
            overflow_r <= 1'b1;
        end else if (CLR_ERR) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign EVT_CODE  = head_s[7:0];
    assign EVT_BREAK = head_s[8];
    assign EVT_EXT   = head_s[9];
    assign OVERFLOW  = overflow_r;
    assign FRAME_ERR = frame_err_r;

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, 8, event FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter FILTER_LEN, 4, consecutive equal CLK samples required to accept a PS2_CLK/PS2_DAT level change.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, 100000, CLK cycles without a PS2_CLK falling edge before a partial frame is abandoned.
REQ-004 SHALL have port CLK  input  1  system clock; single clock domain for all state.
REQ-005 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port PS2_CLK  input  1  raw keyboard clock, asynchronous to CLK.
REQ-007 SHALL have port PS2_DAT  input  1  raw keyboard data, asynchronous to CLK.
REQ-008 SHALL have port EVT_VALID  output  1  FIFO head holds an event.
REQ-009 SHALL have port EVT_READY  input  1  consumer accepts head event.
REQ-010 SHALL have port EVT_CODE  output  8  scancode of head event.
REQ-011 SHALL have port EVT_EXT  output  1  head event was prefixed by E0.
REQ-012 SHALL have port EVT_BREAK  output  1  head event was prefixed by F0 (key release).
REQ-013 SHALL have port FIFO_COUNT  output  $clog2(FIFO_DEPTH+1)  occupied entries.
REQ-014 SHALL have port OVERFLOW  output  1  sticky; an event was dropped because the FIFO was full.
REQ-015 SHALL have port FRAME_ERR  output  1  one-cycle pulse per rejected frame.
REQ-016 SHALL have port CLR_ERR  input  1  synchronous clear of OVERFLOW.

Function
REQ-017 SHALL pass PS2_CLK and PS2_DAT through a 2-flop synchroniser, then a FILTER_LEN glitch filter; a falling edge is a filtered 1->0 transition, detected once.
REQ-018 SHALL sample filtered data on each falling edge using FSM IDLE->DATA(8 bits, LSB first)->PARITY->STOP->IDLE.
REQ-019 SHALL leave IDLE only when the sampled start bit is 0; a start bit of 1 is ignored with no error.
REQ-020 SHALL reject a frame (FRAME_ERR pulse, nothing pushed) when stop bit is 0.
REQ-021 SHALL, in any non-IDLE state, return to IDLE and pulse FRAME_ERR after TIMEOUT_CYCLES cycles with no falling edge; counter restarts on every edge.
REQ-022 SHALL treat byte E0 as setting a pending EXT flag and F0 as setting a pending BREAK flag; neither is pushed.
REQ-023 SHALL push {EXT, BREAK, byte} for any other valid byte except 00/FF, then clear both pending flags.
REQ-024 SHALL drop bytes 00 and FF (keyboard overrun/error) with FRAME_ERR pulse and clear pending flags.
REQ-025 SHALL perform the push in the cycle after the stop-bit edge; EVT_VALID SHALL rise the following cycle (first-word-fall-through, 2-cycle latency from stop edge).
REQ-026 SHALL pop the head on a cycle with EVT_VALID && EVT_READY; EVT_* SHALL hold stable while EVT_VALID && !EVT_READY.
REQ-027 SHALL, on push while full without pop, drop the new event and set OVERFLOW; push and pop in the same cycle when full SHALL both succeed, count unchanged.
REQ-028 SHALL give CLR_ERR priority below a same-cycle overflow set (OVERFLOW stays 1).
REQ-029 SHALL wrap read/write pointers modulo FIFO_DEPTH.

Reset
REQ-030 SHALL, on RST_N low, immediately force: FSM IDLE, shift/bit counters 0, timeout counter 0, pending flags 0, FIFO empty, EVT_VALID 0, EVT_CODE 00, EVT_EXT 0, EVT_BREAK 0, FIFO_COUNT 0, OVERFLOW 0, FRAME_ERR 0; synchroniser and filter outputs 1.
REQ-031 SHALL discard any partial frame on reset; first frame after release is decoded normally.

Configuration
REQ-032 SHALL, with PS2_RX_PARITY_CHECK_EN defined, require odd parity over data+parity bit and reject mismatches per REQ-020.
REQ-033 SHALL, without PS2_RX_PARITY_CHECK_EN, sample and ignore the parity bit.

Structure
REQ-034 SHALL place FSM state encoding, PREFIX_EXT=8'hE0, PREFIX_BRK=8'hF0, and event width constant (10) in shared package ps2_pkg.
REQ-035 SHALL implement the event FIFO as sub-module ps2_evt_fifo (parameter DEPTH, WIDTH=10).

Verification
REQ-036 SHALL cover: frame 1C, parity ok -> one event CODE=1C EXT=0 BREAK=0, EVT_VALID 2 cycles after stop edge.
REQ-037 SHALL cover: E0 F0 75 -> single event CODE=75 EXT=1 BREAK=1, FIFO_COUNT=1.
REQ-038 SHALL cover: frame 1B with wrong parity -> FRAME_ERR pulse, no event (EN defined); event 1B pushed (EN undefined).
REQ-039 SHALL cover: 9 frames, EVT_READY=0, FIFO_DEPTH=8 -> FIFO_COUNT=8, OVERFLOW=1, head still first code; CLR_ERR -> OVERFLOW=0.
REQ-040 SHALL cover: 4 bits then PS2_CLK idle TIMEOUT_CYCLES -> FRAME_ERR pulse, next full frame 2D decoded correctly.
REQ-041 SHALL cover: RST_N low mid-frame after F0 received -> outputs at reset values; next frame 76 yields BREAK=0.
